// File: rtl/vga_capture.sv
// Receive side of the VGA pixel interface: samples hs/vs/rgb, recovers pixel and
// line position from sync edges and writes an IMG_W x IMG_H window into a frame RAM.
module vga_capture #(
    parameter int H_SYNC = 96,
    parameter int V_SYNC = 2,
    parameter int H_BACK = 48,
    parameter int V_BACK = 33,
    parameter int X0     = 0,
    parameter int Y0     = 0,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hs,
    input  logic        vs,
    input  logic [7:0]  rgb,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [12:0] H_OFF   = 13'(H_SYNC + H_BACK + X0);
    localparam logic [12:0] H_END   = 13'(H_SYNC + H_BACK + X0 + IMG_W);
    localparam logic [11:0] V_OFF   = 12'(V_SYNC + V_BACK + Y0);
    localparam logic [11:0] V_END   = 12'(V_SYNC + V_BACK + Y0 + IMG_H);
    localparam logic [7:0]  H_OFF8  = 8'(H_SYNC + H_BACK + X0);
    localparam logic [7:0]  V_OFF8  = 8'(V_SYNC + V_BACK + Y0);
    localparam logic [7:0]  COL_END = 8'(IMG_W - 1);
    localparam logic [7:0]  ROW_END = 8'(IMG_H - 1);

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        logic [11:0] r;
        if (v == 12'hfff) r = v;
        else              r = v + 12'd1;
        return r;
    endfunction

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        logic [10:0] r;
        if (v == 11'h7ff) r = v;
        else              r = v + 11'd1;
        return r;
    endfunction

    logic        hs_r, vs_r, hs_prev_r, vs_prev_r;
    logic [7:0]  rgb_r;
    logic [11:0] p_r, p_s;
    logic [10:0] l_r, l_s;
    logic        hs_fall_s, vs_fall_s, in_win_s, last_s;
    logic [7:0]  col_s, row_s;
    state_t      state_r, state_nxt;
    logic        wr_en_r, wr_en_nxt, done_r, done_nxt, err_r, err_nxt, busy_r;
    logic [15:0] wr_addr_r;
    logic [7:0]  wr_data_r;

    // Input sampling stage plus previous sync levels for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_r      <= 1'b1;
            vs_r      <= 1'b1;
            hs_prev_r <= 1'b1;
            vs_prev_r <= 1'b1;
            rgb_r     <= 8'd0;
        end else begin
            hs_r      <= hs;
            vs_r      <= vs;
            hs_prev_r <= hs_r;
            vs_prev_r <= vs_r;
            rgb_r     <= rgb;
        end
    end

    assign hs_fall_s = hs_prev_r & ~hs_r;
    assign vs_fall_s = vs_prev_r & ~vs_r;

    // Position of the sample currently held in rgb_r; vs edge wins over hs edge
    always_comb begin
        p_s = sat_inc12(p_r);
        l_s = l_r;
        if (hs_fall_s) p_s = 12'd0;
        else           p_s = sat_inc12(p_r);
        if (vs_fall_s)      l_s = 11'd0;
        else if (hs_fall_s) l_s = sat_inc11(l_r);
        else                l_s = l_r;
    end

    // Position counters track the last processed sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r <= 12'd0;
            l_r <= 11'd0;
        end else begin
            p_r <= p_s;
            l_r <= l_s;
        end
    end

    // Range check on full-width positions so a saturated counter never aliases into the window
    assign in_win_s = ({1'b0, p_s} >= H_OFF) && ({1'b0, p_s} < H_END) &&
                      ({1'b0, l_s} >= V_OFF) && ({1'b0, l_s} < V_END);
    assign col_s    = p_s[7:0] - H_OFF8;
    assign row_s    = l_s[7:0] - V_OFF8;
    assign last_s   = in_win_s && (col_s == COL_END) && (row_s == ROW_END);

    // Capture sequencing: arm on start, run from the next frame edge, end on last pixel or early vs
    always_comb begin
        state_nxt = state_r;
        wr_en_nxt = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ARMED;
                    err_nxt   = 1'b0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (vs_fall_s) state_nxt = ST_CAPTURE;
                else           state_nxt = ST_ARMED;
            end
            ST_CAPTURE: begin
                if (vs_fall_s) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end else if (in_win_s) begin
                    wr_en_nxt = 1'b1;
                    if (last_s) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_CAPTURE;
                    end
                end else begin
                    state_nxt = ST_CAPTURE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered RAM write port / status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            wr_en_r   <= 1'b0;
            wr_addr_r <= 16'd0;
            wr_data_r <= 8'd0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_nxt;
            wr_en_r <= wr_en_nxt;
            done_r  <= done_nxt;
            err_r   <= err_nxt;
            busy_r  <= (state_nxt != ST_IDLE);
            if (wr_en_nxt) begin
                wr_addr_r <= {row_s, col_s};
                wr_data_r <= rgb_r;
            end
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign done    = done_r;
    assign err     = err_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture: a frame-level model predicts writes, done
// pulses and busy/err levels; a monitor compares them against the DUT each cycle.
module tb_vga_capture;

    localparam int H_SYNC = 4, H_BACK = 3, X0 = 3, IMG_W = 16, H_ACT = 24, H_FP = 3;
    localparam int V_SYNC = 2, V_BACK = 2, Y0 = 1, IMG_H = 8,  V_ACT = 10, V_FP = 3;
    localparam int HT = H_SYNC + H_BACK + H_ACT + H_FP;
    localparam int VT = V_SYNC + V_BACK + V_ACT + V_FP;
    localparam int HOFF = H_SYNC + H_BACK + X0;
    localparam int VOFF = V_SYNC + V_BACK + Y0;
    localparam int LONG_LEN = 4200;

    logic        clk = 1'b0;
    logic        rst_n, start, hs, vs;
    logic [7:0]  rgb;
    logic        wr_en, busy, done, err;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    vga_capture #(
        .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .H_BACK(H_BACK), .V_BACK(V_BACK),
        .X0(X0), .Y0(Y0), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hs(hs), .vs(vs), .rgb(rgb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { int cy; logic [15:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { int cy; logic err; } dn_t;
    typedef struct packed { int cy; logic busy; logic err; } st_t;

    wr_t wq[$];
    dn_t dq[$];
    st_t sq[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: frame-level capture intent and sync-edge positions
    bit m_armed = 1'b0, m_cap = 1'b0, m_hs_prev = 1'b1, m_vs_prev = 1'b1;
    int m_x = 0, m_y = 0;
    logic exp_busy = 1'b0, exp_err = 1'b0;

    int st_y, st_x, st2_y, st2_x, rs_y, rs_x, long_y;

    function automatic void chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    function automatic void push_wr(input int cy, input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.cy = cy; e.addr = a; e.data = d;
        wq.push_back(e);
    endfunction

    function automatic void push_dn(input int cy, input logic e_err);
        dn_t e;
        e.cy = cy; e.err = e_err;
        dq.push_back(e);
    endfunction

    function automatic void push_st(input int cy, input logic b, input logic e_err);
        st_t e;
        e.cy = cy; e.busy = b; e.err = e_err;
        sq.push_back(e);
    endfunction

    // Drive one pixel and predict its effect; outputs for it are due two clocks later
    task automatic drive_pix(input logic h, input logic v, input logic s);
        logic [7:0] d;
        int c, col, row;
        bit hf, vf;
        d = 8'($urandom);
        hs = h; vs = v; start = s; rgb = d;
        c = cyc;
        hf = m_hs_prev && !h;
        vf = m_vs_prev && !v;
        m_hs_prev = h;
        m_vs_prev = v;
        if (hf) m_x = 0;
        else if (m_x < 4095) m_x++;
        if (vf) m_y = 0;
        else if (hf && m_y < 2047) m_y++;
        if (s && !m_armed && !m_cap) begin
            m_armed = 1'b1;
            push_st(c + 1, 1'b1, 1'b0);
        end
        if (vf) begin
            if (m_cap) begin
                m_cap = 1'b0;
                push_dn(c + 2, 1'b1);
                push_st(c + 2, 1'b0, 1'b1);
            end else if (m_armed) begin
                m_armed = 1'b0;
                m_cap = 1'b1;
            end
        end else if (m_cap && m_x >= HOFF && m_x < HOFF + IMG_W &&
                     m_y >= VOFF && m_y < VOFF + IMG_H) begin
            col = m_x - HOFF;
            row = m_y - VOFF;
            push_wr(c + 2, {8'(row), 8'(col)}, d);
            if (col == IMG_W - 1 && row == IMG_H - 1) begin
                m_cap = 1'b0;
                push_dn(c + 2, 1'b0);
                push_st(c + 2, 1'b0, 1'b0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wq.delete();
        dq.delete();
        sq.delete();
        m_armed = 1'b0; m_cap = 1'b0;
        m_hs_prev = 1'b1; m_vs_prev = 1'b1;
        m_x = 0; m_y = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic cfg(input int sy, input int sx, input int s2y, input int s2x,
                       input int ry, input int rx, input int ly);
        st_y = sy; st_x = sx; st2_y = s2y; st2_x = s2x;
        rs_y = ry; rs_x = rx; long_y = ly;
    endtask

    task automatic drive_frame(input int nlines);
        for (int y = 0; y < nlines; y++) begin
            if (y == long_y) begin
                for (int i = 0; i < LONG_LEN; i++) drive_pix(1'b1, 1'b1, 1'b0);
            end else begin
                for (int x = 0; x < HT; x++) begin
                    if (y == rs_y && x == rs_x) do_reset();
                    drive_pix(x >= H_SYNC, y >= V_SYNC,
                              (y == st_y && x == st_x) || (y == st2_y && x == st2_x));
                end
            end
        end
    endtask

    // Monitor: compare DUT outputs with the scoreboard away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_busy = 1'b0;
            exp_err  = 1'b0;
            chk("rst_wr_en", wr_en, 0);
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_data", wr_data, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", err, 0);
        end else begin
            while (sq.size() > 0 && sq[0].cy <= cyc) begin
                exp_busy = sq[0].busy;
                exp_err  = sq[0].err;
                void'(sq.pop_front());
            end
            chk("busy", busy, exp_busy);
            chk("err", err, exp_err);
            while (wq.size() > 0 && wq[0].cy < cyc) begin
                chk("wr_late", wq[0].cy, cyc);
                void'(wq.pop_front());
            end
            if (wr_en) begin
                if (wq.size() == 0 || wq[0].cy != cyc) begin
                    chk("wr_unexpected", wr_en, 0);
                end else begin
                    chk("wr_addr", wr_addr, wq[0].addr);
                    chk("wr_data", wr_data, wq[0].data);
                    void'(wq.pop_front());
                end
            end else if (wq.size() > 0 && wq[0].cy == cyc) begin
                chk("wr_missing", wr_en, 1);
                void'(wq.pop_front());
            end
            while (dq.size() > 0 && dq[0].cy < cyc) begin
                chk("done_late", dq[0].cy, cyc);
                void'(dq.pop_front());
            end
            if (done) begin
                if (dq.size() == 0 || dq[0].cy != cyc) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    chk("done_err", err, dq[0].err);
                    chk("done_busy", busy, 0);
                    void'(dq.pop_front());
                end
            end else if (dq.size() > 0 && dq[0].cy == cyc) begin
                chk("done_missing", done, 1);
                void'(dq.pop_front());
            end
        end
    end

    // Stimulus: idle frames, full captures, truncation, coincident start, lost hs, reset
    initial begin
        rst_n = 1'b0; start = 1'b0; hs = 1'b1; vs = 1'b1; rgb = 8'd0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) drive_pix(1'b1, 1'b1, 1'b0);

        cfg(-1, -1, -1, -1, -1, -1, -1);
        drive_frame(VT);
        drive_frame(VT);
        cfg(VT - 1, 5, -1, -1, -1, -1, -1);
        drive_frame(VT);
        cfg(VOFF + 3, 12, VT - 1, 5, -1, -1, -1);
        drive_frame(VT);
        cfg(-1, -1, -1, -1, -1, -1, -1);
        drive_frame(VOFF + 5);
        drive_frame(VT);
        cfg(0, 1, -1, -1, -1, -1, -1);
        drive_frame(VT);
        cfg(-1, -1, VT - 1, 5, -1, -1, VOFF + 2);
        drive_frame(VT);
        cfg(-1, -1, VT - 1, 5, VOFF + 3, 12, -1);
        drive_frame(VT);
        cfg(-1, -1, -1, -1, -1, -1, -1);
        drive_frame(VT);
        for (int i = 0; i < 10; i++) drive_pix(1'b1, 1'b1, 1'b0);

        chk("writes_outstanding", wq.size(), 0);
        chk("dones_outstanding", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
